// File: rtl/tdc_pkg.sv
// Shared FSM state encoding and default sizing for the ring-oscillator TDC.
package tdc_pkg;

    localparam int unsigned DEF_COUNT_WIDTH    = 16;
    localparam int unsigned DEF_CYCLE_WIDTH    = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1000;
    localparam int unsigned DEF_SYNC_STAGES    = 2;

    typedef logic [1:0] tdc_state_t;

    localparam tdc_state_t ST_IDLE = 2'd0;
    localparam tdc_state_t ST_RUN  = 2'd1;
    localparam tdc_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/tdc_edge_counter_if.sv
// Control and result handshake bundle between the TDC and its controller/consumer.
interface tdc_edge_counter_if
    import tdc_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int unsigned CYCLE_WIDTH = DEF_CYCLE_WIDTH
);
    logic                   start;
    logic                   stop;
    logic                   ring;
    logic                   ring_en;
    logic [COUNT_WIDTH-1:0] count;
    logic [CYCLE_WIDTH-1:0] cycles;
    logic                   overflow;
    logic                   timeout;
    logic                   valid;
    logic                   ready;
    logic                   busy;

    modport master (
        input  start, stop, ring, ready,
        output ring_en, count, cycles, overflow, timeout, valid, busy
    );

    modport slave (
        output start, stop, ring, ready,
        input  ring_en, count, cycles, overflow, timeout, valid, busy
    );

endinterface

// File: rtl/tdc_sync.sv
// Multi-flop synchronizer bringing the asynchronous ring pulse into the i_clk domain.
module tdc_sync
    import tdc_pkg::*;
#(
    parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], i_d};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/tdc_edge_counter.sv
// Ring-oscillator TDC: counts synchronized ring rising edges and i_clk cycles between
// start and stop/timeout, then holds the latched result until the consumer accepts it.
module tdc_edge_counter
    import tdc_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH    = DEF_COUNT_WIDTH,
    parameter int unsigned CYCLE_WIDTH    = DEF_CYCLE_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic                   i_ring,
    output logic                   o_ring_en,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic [CYCLE_WIDTH-1:0] o_cycles,
    output logic                   o_overflow,
    output logic                   o_timeout,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_busy
);
    localparam logic [CYCLE_WIDTH-1:0] TIMEOUT_LIM = CYCLE_WIDTH'(TIMEOUT_CYCLES);

    tdc_state_t             state_q, state_d;
    logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [CYCLE_WIDTH-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CYCLE_WIDTH-1:0] cyc_next;
    logic                   ovf_q, ovf_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [CYCLE_WIDTH-1:0] cycles_q, cycles_d;
    logic                   overflow_q, overflow_d;
    logic                   timeout_q, timeout_d;
    logic                   ring_s;
    logic                   ring_prev_q, ring_prev_d;
    logic                   ring_rise;

    tdc_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_ring),
        .o_q     (ring_s)
    );

    always_comb begin
        ring_prev_d = ring_s;
        ring_rise   = ring_s & ~ring_prev_q;
        cyc_next    = cyc_cnt_q + CYCLE_WIDTH'(1);

        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        cycles_d   = cycles_q;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d    = ST_RUN;
                    edge_cnt_d = '0;
                    cyc_cnt_d  = '0;
                    ovf_d      = 1'b0;
                end
            end
            ST_RUN: begin
                cyc_cnt_d = cyc_next;
                if (ring_rise) begin
                    if (&edge_cnt_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + COUNT_WIDTH'(1);
                    end
                end
                // Latch from the _d values so an edge in the final RUN cycle is included.
                if (i_stop || (cyc_next == TIMEOUT_LIM)) begin
                    state_d    = ST_DONE;
                    count_d    = edge_cnt_d;
                    cycles_d   = cyc_next;
                    overflow_d = ovf_d;
                    timeout_d  = ~i_stop;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            edge_cnt_q  <= '0;
            cyc_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            cycles_q    <= '0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
            ring_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            edge_cnt_q  <= edge_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
            ovf_q       <= ovf_d;
            count_q     <= count_d;
            cycles_q    <= cycles_d;
            overflow_q  <= overflow_d;
            timeout_q   <= timeout_d;
            ring_prev_q <= ring_prev_d;
        end
    end

    assign o_ring_en  = (state_q == ST_RUN);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_valid    = (state_q == ST_DONE);
    assign o_count    = count_q;
    assign o_cycles   = cycles_q;
    assign o_overflow = overflow_q;
    assign o_timeout  = timeout_q;

endmodule

// File: doc/tdc_edge_counter.md
TDC_EDGE_COUNTER -- requirements
Module: tdc_edge_counter

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16, width of the ring-edge count.
REQ-002 SHALL have parameter CYCLE_WIDTH, default 16, width of the clock-cycle count.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000, RUN length limit in i_clk cycles (1 .. 2^CYCLE_WIDTH-1).
REQ-004 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for i_ring (minimum 2).
REQ-005 SHALL have port i_clk, input, 1, sole clock; one clock, all state on its rising edge.
REQ-006 SHALL have port i_reset, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port i_start, input, 1, synchronous request to begin a measurement.
REQ-008 SHALL have port i_stop, input, 1, synchronous request to end the measurement.
REQ-009 SHALL have port i_ring, input, 1, ring oscillator pulse output, asynchronous to i_clk.
REQ-010 SHALL have port o_ring_en, output, 1, enable to the ring oscillator start input.
REQ-011 SHALL have port o_count, output, COUNT_WIDTH, latched ring rising-edge count.
REQ-012 SHALL have port o_cycles, output, CYCLE_WIDTH, latched i_clk cycles spent in RUN.
REQ-013 SHALL have port o_overflow, output, 1, edge counter saturated during the measurement.
REQ-014 SHALL have port o_timeout, output, 1, measurement ended by timeout, not i_stop.
REQ-015 SHALL have port o_valid, output, 1, result valid.
REQ-016 SHALL have port i_ready, input, 1, consumer accepts result.
REQ-017 SHALL have port o_busy, output, 1, high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE.
REQ-019 IDLE: i_start high SHALL move to RUN next cycle, clearing edge and cycle counters, overflow and timeout flags.
REQ-020 RUN: o_ring_en SHALL be 1; o_ring_en SHALL be 0 in IDLE and DONE.
REQ-021 i_ring SHALL pass SYNC_STAGES flops, then a one-flop rising-edge detector; edge-to-increment latency SHALL be SYNC_STAGES+1 cycles.
REQ-022 RUN: each detected rising edge SHALL increment the edge counter by 1; at all-ones it SHALL saturate and set overflow.
REQ-023 RUN: the cycle counter SHALL increment by 1 every cycle, starting at 1 on the first RUN cycle.
REQ-024 RUN: i_stop high SHALL move to DONE next cycle; an edge detected in the same cycle SHALL be counted.
REQ-025 RUN: cycle counter reaching TIMEOUT_CYCLES without i_stop SHALL move to DONE with timeout set; i_stop in the same cycle SHALL take precedence (timeout clear).
REQ-026 On entering DONE, o_count, o_cycles, o_overflow, o_timeout SHALL be latched and o_valid SHALL rise.
REQ-027 DONE: o_valid and outputs SHALL hold stable until i_ready high; on o_valid&&i_ready SHALL return to IDLE next cycle with o_valid low.
REQ-028 i_start in RUN or DONE, and i_stop in IDLE or DONE, SHALL be ignored.
REQ-029 i_start and i_stop high together in IDLE SHALL start RUN; that i_stop SHALL be ignored.
REQ-030 Latched outputs SHALL retain last result through IDLE until the next DONE entry.
REQ-031 Correct counts SHALL be guaranteed only for i_ring high and low phases each at least 2 i_clk periods.

Reset
REQ-032 i_reset high SHALL immediately force IDLE, o_ring_en=0, o_valid=0, o_busy=0, o_count=0, o_cycles=0, o_overflow=0, o_timeout=0, all counters and synchronizer flops 0.
REQ-033 Reset mid-RUN or mid-DONE SHALL discard the measurement; no o_valid SHALL follow until a new i_start.

Structure
REQ-034 A shared package tdc_pkg SHALL hold the FSM state typedef and default width/timeout constants.
REQ-035 The synchronizer SHALL be a sub-module tdc_sync (parameter STAGES, ports i_clk, i_reset, i_d, o_q).

Verification
REQ-036 Reset then i_start 1 cycle, i_ring period 8 clk, i_stop after 40 RUN cycles -> o_valid, o_cycles=40, o_count=5 ±1, o_overflow=0, o_timeout=0.
REQ-037 TIMEOUT_CYCLES=16, no i_stop -> DONE after 16 RUN cycles, o_timeout=1, o_cycles=16.
REQ-038 COUNT_WIDTH=3, 12 ring edges before i_stop -> o_count=7, o_overflow=1.
REQ-039 i_ready held low 10 cycles in DONE, i_start pulsed -> outputs stable, o_valid=1, no restart; i_ready high -> IDLE next cycle.
REQ-040 Assert i_reset asynchronously mid-RUN -> o_ring_en=0 and o_busy=0 before next clock edge, no o_valid afterward.
REQ-041 i_start and i_stop together in IDLE -> RUN entered; i_stop at TIMEOUT_CYCLES boundary -> o_timeout=0.
